// File: rtl/seq_shifter_if.sv
// seq_shifter_if
//   Request/result bundle for the multi-cycle shift/rotate unit.
//   master: control side (drives start/mode/data_in/num_shifts, observes status).
//   slave : shifter side (observes request, drives busy/done/result/last_out).
//   Signals:
//     start      request pulse, sampled only while the shifter is idle
//     mode       000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others pass-through
//     data_in    operand
//     num_shifts shift amount, only the low clog2(WIDTH) bits are significant
//     busy       high from the accepting edge until done drops
//     done       one-cycle pulse, result valid while high
//     result     shifted/rotated value, held until the next completion
//     last_out   last bit shifted or rotated out
interface seq_shifter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] num_shifts;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             last_out;

  modport master (
    output start, mode, data_in, num_shifts,
    input  busy, done, result, last_out
  );

  modport slave (
    input  start, mode, data_in, num_shifts,
    output busy, done, result, last_out
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter
//   Multi-cycle barrel shift/rotate unit. Each cycle the working register is
//   moved by up to STEP positions in the latched direction until the masked
//   amount is exhausted, then the result is published with a one-cycle done.
//   Parameters:
//     WIDTH  data width, power of two, >= 2
//     STEP   max positions moved per cycle, 1..WIDTH
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous active-high reset
//     bus    seq_shifter_if slave modport (start/mode/data_in/num_shifts in,
//            busy/done/result/last_out out, all outputs registered)
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic          clock,
  input  logic          reset,
  seq_shifter_if.slave  bus
);

  localparam int unsigned AW = $clog2(WIDTH);

  // Per-cycle step clamped to WIDTH-1: the remaining count never exceeds
  // WIDTH-1, so a clamp there yields the same min(STEP, rem).
  localparam logic [AW-1:0] STEP_C = (STEP >= WIDTH) ? {AW{1'b1}} : AW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M_SHR  = 3'b000,
    M_SHRA = 3'b001,
    M_SHL  = 3'b010,
    M_ROR  = 3'b011,
    M_ROL  = 3'b100
  } mode_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [2:0]       r_mode;
  logic [AW-1:0]    r_rem;
  logic             r_last;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_last_out;

  logic             w_mode_valid;
  logic [AW-1:0]    w_k;
  logic [AW-1:0]    w_kinv;
  logic [AW-1:0]    w_idx_r;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_next;
  logic             w_next_last;
  logic             w_unused_ns_hi;

  assign w_mode_valid = (bus.mode <= M_ROL);

  // Upper amount bits are deliberately ignored (amount taken modulo WIDTH).
  assign w_unused_ns_hi = ^bus.num_shifts[WIDTH-1:AW];

  assign w_k     = (r_rem < STEP_C) ? r_rem : STEP_C;
  // WIDTH - k reduced modulo WIDTH; only meaningful for k >= 1.
  assign w_kinv  = AW'(0) - w_k;
  assign w_idx_r = w_k - AW'(1);

  assign w_shr = r_work >> w_k;
  assign w_sra = $signed(r_work) >>> w_k;
  assign w_shl = r_work << w_k;
  assign w_ror = w_shr | (r_work << w_kinv);
  assign w_rol = w_shl | (r_work >> w_kinv);

  // Bit leaving the register on this step: bit k-1 for rightward moves,
  // bit WIDTH-k for leftward moves. Accumulated over all steps this is the
  // original operand's d[n-1] or d[WIDTH-n].
  always_comb begin
    w_next      = r_work;
    w_next_last = r_last;
    case (r_mode)
      M_SHR: begin
        w_next      = w_shr;
        w_next_last = r_work[w_idx_r];
      end
      M_SHRA: begin
        w_next      = w_sra;
        w_next_last = r_work[w_idx_r];
      end
      M_SHL: begin
        w_next      = w_shl;
        w_next_last = r_work[w_kinv];
      end
      M_ROR: begin
        w_next      = w_ror;
        w_next_last = r_work[w_idx_r];
      end
      M_ROL: begin
        w_next      = w_rol;
        w_next_last = r_work[w_kinv];
      end
      default: begin
        w_next      = r_work;
        w_next_last = r_last;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_mode     <= '0;
      r_rem      <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_last_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work  <= bus.data_in;
            r_mode  <= bus.mode;
            // Invalid modes take the zero-amount path: pass-through, last_out=0.
            r_rem   <= w_mode_valid ? bus.num_shifts[AW-1:0] : '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_rem != '0) begin
            r_work <= w_next;
            r_last <= w_next_last;
            r_rem  <= r_rem - w_k;
          end else begin
            r_done     <= 1'b1;
            r_result   <= r_work;
            r_last_out <= r_last;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.last_out = r_last_out;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic [31:0] data_in;
  logic [31:0] num_shifts;

  int tests_run;
  int tests_failed;

  // Observations from the last operation, for STEP=1 (x1) and STEP=8 (x8).
  logic [31:0] r1, r8, pre1, pre8;
  logic        l1, l8, bok1, bok8, idl1, idl8;
  int          lat1, lat8;

  seq_shifter_if #(.WIDTH(32)) bus1 ();
  seq_shifter_if #(.WIDTH(32)) bus8 ();

  assign bus1.start      = start;
  assign bus1.mode       = mode;
  assign bus1.data_in    = data_in;
  assign bus1.num_shifts = num_shifts;
  assign bus8.start      = start;
  assign bus8.mode       = mode;
  assign bus8.data_in    = data_in;
  assign bus8.num_shifts = num_shifts;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  seq_shifter #(.WIDTH(32), .STEP(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one request to both instances and record result, last_out, the
  // edge at which done is seen (accept edge = 0), busy continuity, the idle
  // state one edge after done, and the result right after the accept edge.
  task automatic do_op(input logic [2:0] m, input logic [31:0] d, input logic [31:0] n);
    @(negedge clock);
    start = 1'b1; mode = m; data_in = d; num_shifts = n;
    lat1 = -1; lat8 = -1; bok1 = 1'b1; bok8 = 1'b1; idl1 = 1'b0; idl8 = 1'b0;
    r1 = 'x; r8 = 'x; l1 = 1'bx; l8 = 1'bx;
    for (int e = 0; e < 64; e++) begin
      @(posedge clock); #1;
      if (e == 0) begin
        start = 1'b0; data_in = ~d; num_shifts = n + 32'd3; mode = m ^ 3'b001;
        pre1 = bus1.result; pre8 = bus8.result;
      end
      if (lat1 < 0) begin
        if (!bus1.busy) bok1 = 1'b0;
        if (bus1.done) begin lat1 = e; r1 = bus1.result; l1 = bus1.last_out; end
      end else if (e == lat1 + 1) idl1 = !bus1.busy && !bus1.done;
      if (lat8 < 0) begin
        if (!bus8.busy) bok8 = 1'b0;
        if (bus8.done) begin lat8 = e; r8 = bus8.result; l8 = bus8.last_out; end
      end else if (e == lat8 + 1) idl8 = !bus8.busy && !bus8.done;
      if (lat1 >= 0 && lat8 >= 0 && e > lat1 && e > lat8) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = '0; data_in = '0; num_shifts = '0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++; if (bus1.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
    tests_run++; if (bus1.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus1.done); end
    tests_run++; if (bus1.result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", bus1.result); end
    tests_run++; if (bus1.last_out !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got %b want 0", bus1.last_out); end
    tests_run++; if (bus8.busy !== 1'b0 || bus8.result !== 32'h0) begin tests_failed++; $display("FAIL reset_x8: got busy %b result %h want 0/0", bus8.busy, bus8.result); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_shr();
    do_op(3'b000, 32'hFFFFFFF0, 32'd1);
    tests_run++; if (r1 !== 32'h7FFFFFF8) begin tests_failed++; $display("FAIL shr_result: got %h want 7ffffff8", r1); end
    tests_run++; if (l1 !== 1'b0) begin tests_failed++; $display("FAIL shr_last: got %b want 0", l1); end
    tests_run++; if (lat1 !== 2) begin tests_failed++; $display("FAIL shr_latency: got %0d want 2", lat1); end
    tests_run++; if (bok1 !== 1'b1) begin tests_failed++; $display("FAIL shr_busy_held: got %b want 1", bok1); end
    tests_run++; if (idl1 !== 1'b1) begin tests_failed++; $display("FAIL shr_idle_after_done: got %b want 1", idl1); end
    tests_run++; if (r8 !== 32'h7FFFFFF8 || lat8 !== 2) begin tests_failed++; $display("FAIL shr_x8: got %h lat %0d want 7ffffff8 lat 2", r8, lat8); end
  endtask

  task automatic test_shra();
    do_op(3'b001, 32'h80000000, 32'd31);
    tests_run++; if (r1 !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL shra_result: got %h want ffffffff", r1); end
    tests_run++; if (l1 !== 1'b0) begin tests_failed++; $display("FAIL shra_last: got %b want 0", l1); end
    tests_run++; if (lat1 !== 32) begin tests_failed++; $display("FAIL shra_latency_x1: got %0d want 32", lat1); end
    tests_run++; if (lat8 !== 5) begin tests_failed++; $display("FAIL shra_latency_x8: got %0d want 5", lat8); end
    tests_run++; if (r8 !== 32'hFFFFFFFF || bok8 !== 1'b1) begin tests_failed++; $display("FAIL shra_x8: got %h busyok %b want ffffffff 1", r8, bok8); end
    do_op(3'b001, 32'h40000000, 32'd4);
    tests_run++; if (r1 !== 32'h04000000 || r8 !== 32'h04000000) begin tests_failed++; $display("FAIL shra_positive: got %h/%h want 04000000", r1, r8); end
  endtask

  task automatic test_rotate_shl();
    do_op(3'b100, 32'h80000001, 32'd4);
    tests_run++; if (r1 !== 32'h00000018 || l1 !== 1'b0) begin tests_failed++; $display("FAIL rol4: got %h last %b want 00000018 0", r1, l1); end
    tests_run++; if (r8 !== 32'h00000018 || lat8 !== 2) begin tests_failed++; $display("FAIL rol4_x8: got %h lat %0d want 00000018 2", r8, lat8); end
    do_op(3'b011, 32'h00000001, 32'd1);
    tests_run++; if (r1 !== 32'h80000000 || l1 !== 1'b1) begin tests_failed++; $display("FAIL ror1: got %h last %b want 80000000 1", r1, l1); end
    do_op(3'b010, 32'h80000000, 32'd1);
    tests_run++; if (r1 !== 32'h00000000 || l1 !== 1'b1) begin tests_failed++; $display("FAIL shl1: got %h last %b want 00000000 1", r1, l1); end
    do_op(3'b100, 32'h12345678, 32'd12);
    tests_run++; if (r1 !== 32'h45678123 || l1 !== 1'b1) begin tests_failed++; $display("FAIL rol12: got %h last %b want 45678123 1", r1, l1); end
    tests_run++; if (r8 !== 32'h45678123 || l8 !== 1'b1 || lat8 !== 3) begin tests_failed++; $display("FAIL rol12_x8: got %h last %b lat %0d want 45678123 1 3", r8, l8, lat8); end
    tests_run++; if (lat1 !== 13) begin tests_failed++; $display("FAIL rol12_latency: got %0d want 13", lat1); end
    do_op(3'b011, 32'h12345678, 32'd8);
    tests_run++; if (r8 !== 32'h78123456 || l8 !== 1'b0) begin tests_failed++; $display("FAIL ror8_x8: got %h last %b want 78123456 0", r8, l8); end
    do_op(3'b000, 32'hF0000800, 32'd12);
    tests_run++; if (r8 !== 32'h000F0000 || l8 !== 1'b1) begin tests_failed++; $display("FAIL shr12_x8: got %h last %b want 000f0000 1", r8, l8); end
  endtask

  task automatic test_masking();
    do_op(3'b010, 32'h00000001, 32'd33);
    tests_run++; if (r1 !== 32'h00000002 || lat1 !== 2) begin tests_failed++; $display("FAIL mask33: got %h lat %0d want 00000002 2", r1, lat1); end
    do_op(3'b000, 32'hDEADBEEF, 32'd0);
    tests_run++; if (r1 !== 32'hDEADBEEF || l1 !== 1'b0) begin tests_failed++; $display("FAIL zero_amount: got %h last %b want deadbeef 0", r1, l1); end
    tests_run++; if (lat1 !== 1 || lat8 !== 1) begin tests_failed++; $display("FAIL zero_latency: got %0d/%0d want 1/1", lat1, lat8); end
    do_op(3'b101, 32'hCAFEF00D, 32'd64);
    tests_run++; if (r1 !== 32'hCAFEF00D || lat1 !== 1) begin tests_failed++; $display("FAIL mask64_mode5: got %h lat %0d want cafef00d 1", r1, lat1); end
    do_op(3'b111, 32'hA5A5A5A5, 32'd5);
    tests_run++; if (r1 !== 32'hA5A5A5A5 || l1 !== 1'b0) begin tests_failed++; $display("FAIL invalid_mode: got %h last %b want a5a5a5a5 0", r1, l1); end
    tests_run++; if (lat1 !== 1 || idl1 !== 1'b1) begin tests_failed++; $display("FAIL invalid_latency: got %0d idle %b want 1 1", lat1, idl1); end
  endtask

  task automatic test_ignore_start();
    int  la1, la8;
    logic [31:0] ra1, ra8;
    @(negedge clock);
    start = 1'b1; mode = 3'b000; data_in = 32'hFFFF0000; num_shifts = 32'd8;
    la1 = -1; la8 = -1; ra1 = 'x; ra8 = 'x;
    @(posedge clock); #1;
    // Keep start high for two more edges with different operands.
    mode = 3'b010; data_in = 32'h12345678; num_shifts = 32'd3;
    for (int e = 1; e < 40; e++) begin
      @(posedge clock); #1;
      if (e == 2) start = 1'b0;
      if (la1 < 0 && bus1.done) begin la1 = e; ra1 = bus1.result; end
      if (la8 < 0 && bus8.done) begin la8 = e; ra8 = bus8.result; end
      if (la1 >= 0 && e > la1) break;
    end
    tests_run++; if (ra1 !== 32'h00FFFF00 || la1 !== 9) begin tests_failed++; $display("FAIL ignore_start: got %h lat %0d want 00ffff00 9", ra1, la1); end
    tests_run++; if (ra8 !== 32'h00FFFF00 || la8 !== 2) begin tests_failed++; $display("FAIL ignore_start_x8: got %h lat %0d want 00ffff00 2", ra8, la8); end
    tests_run++; if (bus1.busy !== 1'b0 || bus8.busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_start_idle: got %b/%b want 0/0", bus1.busy, bus8.busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    start = 1'b1; mode = 3'b001; data_in = 32'h80000000; num_shifts = 32'd31;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    tests_run++; if (bus1.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_shift_busy: got %b want 1", bus1.busy); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    tests_run++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_flags: got busy %b done %b want 0 0", bus1.busy, bus1.done); end
    tests_run++; if (bus1.result !== 32'h0 || bus8.result !== 32'h0) begin tests_failed++; $display("FAIL mid_reset_result: got %h/%h want 0", bus1.result, bus8.result); end
    @(negedge clock);
    reset = 1'b0;
    do_op(3'b011, 32'h00000001, 32'd1);
    tests_run++; if (r1 !== 32'h80000000 || l1 !== 1'b1 || lat1 !== 2) begin tests_failed++; $display("FAIL after_reset_op: got %h last %b lat %0d want 80000000 1 2", r1, l1, lat1); end
  endtask

  task automatic test_back_to_back();
    do_op(3'b010, 32'h0000000F, 32'd4);
    tests_run++; if (r1 !== 32'h000000F0 || lat1 !== 5) begin tests_failed++; $display("FAIL b2b_first: got %h lat %0d want 000000f0 5", r1, lat1); end
    do_op(3'b000, 32'hF0000000, 32'd12);
    tests_run++; if (pre1 !== 32'h000000F0 || pre8 !== 32'h000000F0) begin tests_failed++; $display("FAIL b2b_result_held: got %h/%h want 000000f0", pre1, pre8); end
    tests_run++; if (r1 !== 32'h000F0000 || l1 !== 1'b0 || lat1 !== 13) begin tests_failed++; $display("FAIL b2b_second: got %h last %b lat %0d want 000f0000 0 13", r1, l1, lat1); end
    tests_run++; if (r8 !== 32'h000F0000 || lat8 !== 3) begin tests_failed++; $display("FAIL b2b_second_x8: got %h lat %0d want 000f0000 3", r8, lat8); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_shr();
    test_shra();
    test_rotate_shl();
    test_masking();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
